// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and load responses into one registered
// register-file write per cycle, buffering blocked ALU results in an in-order FIFO.
module writeback_unit #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        ld_valid,
   input  logic [4:0]  ld_rd,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_offset,
   input  logic [31:0] ld_rdata,
   output logic        w_enabled,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        ld_err,
   output logic        busy
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } load_kind_e;

   logic [4:0]       fifo_rd   [DEPTH];
   logic [31:0]      fifo_data [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] head_d;
   logic [PTR_W-1:0] tail_q;
   logic [PTR_W-1:0] tail_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   logic        alu_keep;
   logic        ld_legal;
   logic        ld_write;
   logic        fifo_empty;
   logic        do_pop;
   logic        do_direct;
   logic        do_push;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_value;
   logic        w_en_d;
   logic [4:0]  rd_addr_d;
   logic [31:0] rd_data_d;

   always_comb begin
      ld_byte  = ld_rdata[7:0];
      ld_half  = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
      ld_legal = 1'b1;
      ld_value = '0;
      case (ld_offset)
         2'd1:    ld_byte = ld_rdata[15:8];
         2'd2:    ld_byte = ld_rdata[23:16];
         2'd3:    ld_byte = ld_rdata[31:24];
         default: ld_byte = ld_rdata[7:0];
      endcase
      case (ld_funct3)
         F3_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
         F3_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
         F3_LW:   ld_value = ld_rdata;
         F3_LBU:  ld_value = {24'h0, ld_byte};
         F3_LHU:  ld_value = {16'h0, ld_half};
         default: ld_legal = 1'b0;
      endcase
   end

   // Only a load that really writes occupies the port; dropped loads let the FIFO drain.
   always_comb begin
      alu_keep   = alu_valid && alu_ready && (alu_rd != 5'd0);
      ld_write   = ld_valid && ld_legal && (ld_rd != 5'd0);
      fifo_empty = (count_q == '0);
      do_pop     = !ld_write && !fifo_empty;
      do_direct  = alu_keep && !ld_valid && fifo_empty;
      do_push    = alu_keep && !do_direct;

      w_en_d    = 1'b0;
      rd_addr_d = '0;
      rd_data_d = '0;
      if (ld_write) begin
         w_en_d    = 1'b1;
         rd_addr_d = ld_rd;
         rd_data_d = ld_value;
      end else if (do_pop) begin
         w_en_d    = 1'b1;
         rd_addr_d = fifo_rd[head_q];
         rd_data_d = fifo_data[head_q];
      end else if (do_direct) begin
         w_en_d    = 1'b1;
         rd_addr_d = alu_rd;
         rd_data_d = alu_data;
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (do_pop) begin
         head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
      end
      if (do_push) begin
         tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         fifo_rd[tail_q]   <= alu_rd;
         fifo_data[tail_q] <= alu_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         w_enabled <= 1'b0;
         rd_addr   <= '0;
         rd_data   <= '0;
         ld_err    <= 1'b0;
         busy      <= 1'b0;
         alu_ready <= 1'b1;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         w_enabled <= w_en_d;
         rd_addr   <= rd_addr_d;
         rd_data   <= rd_data_d;
         ld_err    <= ld_valid && !ld_legal;
         busy      <= (count_d != '0) || w_en_d;
         alu_ready <= (count_d < FULL_CNT);
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed steps followed by random traffic,
// all compared against a queue-based reference model of the writeback rules.
module tb_writeback_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_offset;
   logic [31:0] ld_rdata;
   logic        w_enabled;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        ld_err;
   logic        busy;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } result_t;

   result_t     pend[$];
   logic        exp_we;
   logic [4:0]  exp_addr;
   logic [31:0] exp_data;
   logic        exp_err;
   logic        exp_busy;
   logic        exp_ready;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   writeback_unit #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .ld_valid  (ld_valid),
      .ld_rd     (ld_rd),
      .ld_funct3 (ld_funct3),
      .ld_offset (ld_offset),
      .ld_rdata  (ld_rdata),
      .w_enabled (w_enabled),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .ld_err    (ld_err),
      .busy      (busy)
   );

   // Returns {legal, value} for a load, computed by shifting and arithmetic sign extension.
   function automatic logic [32:0] loadResult(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
      logic [31:0] b;
      logic [31:0] h;
      b = (word >> (8 * off)) & 32'h0000_00FF;
      h = (word >> (16 * off[1])) & 32'h0000_FFFF;
      case (f3)
         3'd0:    return {1'b1, (b >= 32'd128) ? b - 32'd256 : b};
         3'd1:    return {1'b1, (h >= 32'd32768) ? h - 32'd65536 : h};
         3'd2:    return {1'b1, word};
         3'd4:    return {1'b1, b};
         3'd5:    return {1'b1, h};
         default: return 33'd0;
      endcase
   endfunction

   task automatic modelReset();
      pend.delete();
      exp_we    = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
      exp_err   = 1'b0;
      exp_busy  = 1'b0;
      exp_ready = 1'b1;
   endtask

   task automatic modelStep();
      logic [32:0] lr;
      logic        keep;
      result_t     r;
      lr       = loadResult(ld_funct3, ld_offset, ld_rdata);
      keep     = alu_valid && exp_ready && (alu_rd != 5'd0);
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_err  = ld_valid && !lr[32];
      if (ld_valid && lr[32] && (ld_rd != 5'd0)) begin
         exp_we   = 1'b1;
         exp_addr = ld_rd;
         exp_data = lr[31:0];
      end else if (pend.size() != 0) begin
         r        = pend.pop_front();
         exp_we   = 1'b1;
         exp_addr = r.rd;
         exp_data = r.data;
      end else if (keep && !ld_valid) begin
         exp_we   = 1'b1;
         exp_addr = alu_rd;
         exp_data = alu_data;
         keep     = 1'b0;
      end
      if (keep) begin
         r.rd   = alu_rd;
         r.data = alu_data;
         pend.push_back(r);
      end
      exp_ready = (pend.size() < DEPTH);
      exp_busy  = (pend.size() != 0) || exp_we;
   endtask

   task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                input logic lv, input logic [4:0] lrd, input logic [2:0] lf3,
                                input logic [1:0] loff, input logic [31:0] lword);
      alu_valid = av;
      alu_rd    = ard;
      alu_data  = adata;
      ld_valid  = lv;
      ld_rd     = lrd;
      ld_funct3 = lf3;
      ld_offset = loff;
      ld_rdata  = lword;
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
   endtask

   task automatic checkOutput(input string tag);
      tests++;
      assert (w_enabled === exp_we) else begin
         fails++;
         $error("[TB] FAIL %s w_enabled got %0b want %0b", tag, w_enabled, exp_we);
      end
      if (exp_we) begin
         tests++;
         assert (rd_addr === exp_addr) else begin
            fails++;
            $error("[TB] FAIL %s rd_addr got %0d want %0d", tag, rd_addr, exp_addr);
         end
         tests++;
         assert (rd_data === exp_data) else begin
            fails++;
            $error("[TB] FAIL %s rd_data got %h want %h", tag, rd_data, exp_data);
         end
      end
      tests++;
      assert (ld_err === exp_err) else begin
         fails++;
         $error("[TB] FAIL %s ld_err got %0b want %0b", tag, ld_err, exp_err);
      end
      tests++;
      assert (busy === exp_busy) else begin
         fails++;
         $error("[TB] FAIL %s busy got %0b want %0b", tag, busy, exp_busy);
      end
      tests++;
      assert (alu_ready === exp_ready) else begin
         fails++;
         $error("[TB] FAIL %s alu_ready got %0b want %0b", tag, alu_ready, exp_ready);
      end
   endtask

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("[TB] FAIL %s got %h want %h", tag, got, want);
      end
   endtask

   initial begin
      rstn = 1'b0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_offset = '0; ld_rdata = '0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset");
      checkValue("reset_addr", {27'd0, rd_addr}, 32'd0);
      checkValue("reset_data", rd_data, 32'd0);
      rstn = 1'b1;

      // Single ALU result written directly
      applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
      checkOutput("alu_direct");
      checkValue("alu_direct_we", {31'd0, w_enabled}, 32'd1);
      checkValue("alu_direct_data", rd_data, 32'h1234_5678);
      idleCycle();
      checkOutput("alu_direct_after");
      checkValue("alu_after_busy", {31'd0, busy}, 32'd0);

      // Load wins arbitration, ALU follows a cycle later
      applyStimulus(1'b1, 5'd4, 32'h0000_0011, 1'b1, 5'd3, 3'd2, 2'd0, 32'hDEAD_BEEF);
      checkOutput("lw_vs_alu_1");
      checkValue("lw_data", rd_data, 32'hDEAD_BEEF);
      idleCycle();
      checkOutput("lw_vs_alu_2");
      checkValue("queued_alu_data", rd_data, 32'h0000_0011);
      idleCycle();
      checkOutput("lw_vs_alu_3");

      // Load extraction
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 3'd0, 2'd0, 32'h8070_F0A5);
      checkOutput("lb_off0");
      checkValue("lb_off0_val", rd_data, 32'hFFFF_FFA5);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 3'd4, 2'd1, 32'h8070_F0A5);
      checkOutput("lbu_off1");
      checkValue("lbu_off1_val", rd_data, 32'h0000_00F0);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 3'd1, 2'd2, 32'h8070_F0A5);
      checkOutput("lh_off2");
      checkValue("lh_off2_val", rd_data, 32'hFFFF_8070);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 3'd5, 2'd3, 32'h8070_F0A5);
      checkOutput("lhu_off3");
      checkValue("lhu_off3_val", rd_data, 32'h0000_8070);

      // Loads stall the port; FIFO fills and backpressures
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(10 + i), 32'hA000_0000 + i, 1'b1, 5'(20 + i), 3'd2, 2'd0,
                       32'hB000_0000 + i);
         checkOutput($sformatf("stall%0d", i));
      end
      checkValue("stall_ready_low", {31'd0, alu_ready}, 32'd0);
      idleCycle();
      checkOutput("drain0");
      checkValue("drain0_addr", {27'd0, rd_addr}, 32'd10);
      idleCycle();
      checkOutput("drain1");
      checkValue("drain1_addr", {27'd0, rd_addr}, 32'd11);
      idleCycle();
      checkOutput("drain2");
      checkValue("drain_ready_high", {31'd0, alu_ready}, 32'd1);

      // Discards and illegal load type
      applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
      checkOutput("alu_rd0");
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 3'd2, 2'd0, 32'h5555_5555);
      checkOutput("ld_rd0");
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 3'd3, 2'd0, 32'h5555_5555);
      checkOutput("ld_illegal");
      checkValue("ld_err_pulse", {31'd0, ld_err}, 32'd1);
      idleCycle();
      checkOutput("ld_illegal_after");

      // Fill FIFO then reset asynchronously mid-cycle
      applyStimulus(1'b1, 5'd14, 32'h0000_0E0E, 1'b1, 5'd24, 3'd2, 2'd0, 32'h1);
      checkOutput("fill0");
      applyStimulus(1'b1, 5'd15, 32'h0000_0F0F, 1'b1, 5'd25, 3'd2, 2'd0, 32'h2);
      checkOutput("fill1");
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      #3;
      rstn = 1'b0;
      modelReset();
      #1;
      checkOutput("async_reset");
      @(posedge clk);
      #1;
      checkOutput("reset_held");
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idleCycle();
         checkOutput($sformatf("post_reset%0d", i));
      end

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                       ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)),
                       3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
         checkOutput($sformatf("rand%0d", i));
      end
      for (int i = 0; i < 4; i++) begin
         idleCycle();
         checkOutput($sformatf("rand_drain%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage of the RISC-V core, directly upstream of the register file's write port. It merges single-cycle ALU results and load responses from the data memory into one registered write per cycle (`w_enabled`/`rd_addr`/`rd_data`). Load data is byte/halfword-extracted and sign/zero-extended here. ALU results that lose arbitration are buffered in a small in-order FIFO, with backpressure to the execute stage.

## Interface
- `DEPTH`, 2, ALU result FIFO entries (≥1)
- `clk`  input  1  clock, all state on rising edge
- `rstn`  input  1  reset, asynchronous, active-low
- `alu_valid`  input  1  ALU result present this cycle
- `alu_rd`  input  5  ALU destination register
- `alu_data`  input  32  ALU result
- `alu_ready`  output  1  unit can accept an ALU result this cycle
- `ld_valid`  input  1  load response present; cannot be stalled
- `ld_rd`  input  5  load destination register
- `ld_funct3`  input  3  load type (RV32I encoding)
- `ld_offset`  input  2  byte address bits [1:0] of the load
- `ld_rdata`  input  32  aligned 32-bit word read from memory
- `w_enabled`  output  1  register file write strobe
- `rd_addr`  output  5  register file write address
- `rd_data`  output  32  register file write data
- `ld_err`  output  1  one-cycle pulse: load with illegal `ld_funct3` dropped
- `busy`  output  1  FIFO non-empty or write in flight

## Operation
- Exactly zero or one register write issued per cycle. Priority: load > FIFO head > new ALU result.
- ALU accept: `alu_valid && alu_ready`. `alu_ready` = FIFO count < DEPTH, taken from registered state only (no combinational path from `ld_valid`).
- Accepted ALU result with `alu_rd == 0`: discarded, never queued or written.
- Accepted ALU result, `ld_valid` low, FIFO empty: written directly. Otherwise it is enqueued at the tail.
- FIFO head pops and is written in any cycle with `ld_valid` low. Enqueue and pop in the same cycle are allowed, and the count is unchanged.
- ALU results are written strictly in acceptance order.
- No ordering exists between the load and ALU ports. Issue logic guarantees they never target the same rd while both are outstanding.
- Load with `ld_rd == 0`: discarded; `ld_err` still pulses if funct3 is illegal.
- Load extraction, with byte = `ld_rdata[8*ld_offset +: 8]` and half = `ld_rdata[16*ld_offset[1] +: 16]` (`ld_offset[0]` ignored for halves):
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word; offset ignored.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 011, 110, 111: no write, `ld_err` = 1 next cycle. The FIFO head may pop that cycle instead.
- `busy` = (count != 0) || `w_enabled`.

## Timing
- All outputs registered. Reset values:
  - `w_enabled`, `rd_addr`, `rd_data`, `ld_err`, `busy`: 0.
  - FIFO count: 0.
  - `alu_ready`: 1.
- Latency, input cycle N to `w_enabled` at N+1:
  - Load: always 1 cycle.
  - ALU: 1 cycle when unblocked. Each blocked ALU result waits one extra cycle per load arriving ahead of it, plus one per older queued entry.
- `alu_ready` falls in the cycle after the enqueue that fills the FIFO, and rises in the cycle after a pop.
- `w_enabled` is a one-cycle strobe per result. Back-to-back writes keep it high across cycles with new addr/data.
- Continuous `ld_valid` starves the FIFO. This is by design, because the memory interface bounds load bursts.
- `rstn` low mid-operation: all queued results are lost, and outputs go to reset values immediately (asynchronous). No write is issued in the first cycle after release unless inputs are valid in that cycle.

## Test plan
- Reset then a single ALU result (rd=5, 0x1234_5678) → next cycle `w_enabled`=1, `rd_addr`=5, `rd_data`=0x1234_5678; following cycle `w_enabled`=0, `busy`=0.
- Same cycle: load LW (rd=3, data 0xDEAD_BEEF) and ALU (rd=4, 0x11) → cycle+1 writes x3=0xDEAD_BEEF, cycle+2 writes x4=0x11.
- Load extension on `ld_rdata`=0x8070_F0A5:
  - LB off 0 → 0xFFFF_FFA5; LBU off 1 → 0x0000_00F0.
  - LH off 2 → 0xFFFF_8070; LHU off 3 → 0x0000_8070.
- With DEPTH=2, hold `ld_valid` for 4 cycles while offering ALU results each cycle → two accepted, then `alu_ready`=0. After the loads stop, the queued ALU results are written in order, then `alu_ready`=1.
- ALU rd=0 and load rd=0 → no `w_enabled`. Load funct3=011 → no write, `ld_err`=1 for exactly one cycle.
- With the FIFO holding two entries, pulse `rstn` low mid-cycle → outputs are 0 immediately, `alu_ready`=1. After release, no stale writes appear.
